// File: rtl/true_dual_port_ram.sv
// ---------------------------------------------------------------------------
// true_dual_port_ram
//
// Two fully independent read/write ports (A and B) on a shared DEPTH-word
// memory. Writes use per-byte enables. After reset the array is swept to
// zero, one word per cycle, while busy is high. Requests are ignored during
// the sweep.
//
// Optional feature macro: DPRAM_OUTREG_EN
//   Undefined : read latency 1 (rdata/rvalid on the edge after the request).
//   Defined   : one extra register on rdata/rvalid per port (latency 2).
//
// Parameters
//   DATA_W   word width, multiple of 8 (8..64)
//   ADDR_W   address width, DEPTH = 2**ADDR_W
//   RDW_MODE cross-port read-during-write: 0 = old data, 1 = new data
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   x_en, x_we             request strobe, 1 = write / 0 = read (x = a, b)
//   x_be                   byte enables for writes
//   x_addr, x_wdata        word address (modulo DEPTH), write data
//   x_rdata, x_rvalid      registered read data, one-cycle valid pulse
//   busy                   memory clear in progress
//   collision              pulse: both ports wrote the same address
// ---------------------------------------------------------------------------
module true_dual_port_ram #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int RDW_MODE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_en,
    input  logic                a_we,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic [DATA_W-1:0]   a_rdata,
    output logic                a_rvalid,
    input  logic                b_en,
    input  logic                b_we,
    input  logic [DATA_W/8-1:0] b_be,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_wdata,
    output logic [DATA_W-1:0]   b_rdata,
    output logic                b_rvalid,
    output logic                busy,
    output logic                collision
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BYTES = DATA_W / 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   clr_addr_reg, clr_addr_next;
    logic                clr_we;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= CLEAR;
            clr_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        case (state_reg)
            CLEAR: begin
                clr_addr_next = clr_addr_reg + 1'b1;
                if (clr_addr_reg == {ADDR_W{1'b1}}) begin
                    state_next = READY;
                end
            end
            READY: begin
                state_next = READY;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy   = (state_reg != READY);
        clr_we = (state_reg != READY);
    end

    // Requests are only honoured in READY and never on a reset cycle, so a
    // reset arriving while READY cannot corrupt memory or launch a read.
    logic accept;
    logic a_wr, a_rd, b_wr, b_rd;

    assign accept = (state_reg == READY) && !reset;
    assign a_wr   = accept && a_en && a_we;
    assign a_rd   = accept && a_en && !a_we;
    assign b_wr   = accept && b_en && b_we;
    assign b_rd   = accept && b_en && !b_we;

    // ---------------- storage ----------------
    logic [DATA_W-1:0] mem [DEPTH];

    // Port A's byte assignment comes last so it overrides port B on the
    // bytes both ports enable at the same address.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr_reg] <= '0;
        end else begin
            for (int i = 0; i < BYTES; i++) begin
                if (b_wr && b_be[i]) begin
                    mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
                end
                if (a_wr && a_be[i]) begin
                    mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
                end
            end
        end
    end

    // ---------------- read path with cross-port forwarding ----------------
    logic [DATA_W-1:0] a_rword, b_rword;
    logic [DATA_W-1:0] a_fwd, b_fwd;

    assign a_rword = mem[a_addr];
    assign b_rword = mem[b_addr];

    // In new-data mode, bytes the other port is writing this cycle are
    // substituted into the read word; otherwise the pre-write word is used.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_fwd
            assign a_fwd[gi*8 +: 8] =
                (RDW_MODE != 0 && b_wr && b_addr == a_addr && b_be[gi])
                    ? b_wdata[gi*8 +: 8] : a_rword[gi*8 +: 8];
            assign b_fwd[gi*8 +: 8] =
                (RDW_MODE != 0 && a_wr && a_addr == b_addr && a_be[gi])
                    ? a_wdata[gi*8 +: 8] : b_rword[gi*8 +: 8];
        end
    endgenerate

    logic [DATA_W-1:0] a_rdata_reg, b_rdata_reg;
    logic              a_rvalid_reg, b_rvalid_reg;
    logic              collision_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_rdata_reg   <= '0;
            b_rdata_reg   <= '0;
            a_rvalid_reg  <= 1'b0;
            b_rvalid_reg  <= 1'b0;
            collision_reg <= 1'b0;
        end else begin
            a_rvalid_reg  <= a_rd;
            b_rvalid_reg  <= b_rd;
            if (a_rd) begin
                a_rdata_reg <= a_fwd;
            end
            if (b_rd) begin
                b_rdata_reg <= b_fwd;
            end
            collision_reg <= a_wr && b_wr && (a_addr == b_addr);
        end
    end

    assign collision = collision_reg;

`ifdef DPRAM_OUTREG_EN
    // Second output stage: follows the first stage only when it holds a
    // completed read, so rdata keeps its last value between reads.
    logic [DATA_W-1:0] a_rdata_out_reg, b_rdata_out_reg;
    logic              a_rvalid_out_reg, b_rvalid_out_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_rdata_out_reg  <= '0;
            b_rdata_out_reg  <= '0;
            a_rvalid_out_reg <= 1'b0;
            b_rvalid_out_reg <= 1'b0;
        end else begin
            a_rvalid_out_reg <= a_rvalid_reg;
            b_rvalid_out_reg <= b_rvalid_reg;
            if (a_rvalid_reg) begin
                a_rdata_out_reg <= a_rdata_reg;
            end
            if (b_rvalid_reg) begin
                b_rdata_out_reg <= b_rdata_reg;
            end
        end
    end

    assign a_rdata  = a_rdata_out_reg;
    assign b_rdata  = b_rdata_out_reg;
    assign a_rvalid = a_rvalid_out_reg;
    assign b_rvalid = b_rvalid_out_reg;
`else
    assign a_rdata  = a_rdata_reg;
    assign b_rdata  = b_rdata_reg;
    assign a_rvalid = a_rvalid_reg;
    assign b_rvalid = b_rvalid_reg;
`endif

endmodule

// File: doc/true_dual_port_ram.md
TRUE_DUAL_PORT_RAM -- requirements
Module: true_dual_port_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 16, word width in bits, a multiple of 8 (8..64).
REQ-002 SHALL have parameter ADDR_W, default 4, address width; depth DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter RDW_MODE, default 0, cross-port read-during-write (0 = old data, 1 = new data).
REQ-004 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports a_en / b_en  input  1  port request strobe.
REQ-007 SHALL have ports a_we / b_we  input  1  1 = write, 0 = read (qualified by en).
REQ-008 SHALL have ports a_be / b_be  input  DATA_W/8  byte enables for writes; bit i covers byte i.
REQ-009 SHALL have ports a_addr / b_addr  input  ADDR_W  word address.
REQ-010 SHALL have ports a_wdata / b_wdata  input  DATA_W  write data.
REQ-011 SHALL have ports a_rdata / b_rdata  output  DATA_W  read data, registered.
REQ-012 SHALL have ports a_rvalid / b_rvalid  output  1  one-cycle pulse marking valid rdata.
REQ-013 SHALL have port busy  output  1  memory clear in progress; requests ignored.
REQ-014 SHALL have port collision  output  1  one-cycle pulse: both ports wrote the same address.

Function
REQ-015 SHALL implement a two-state FSM, CLEAR and READY; reset forces CLEAR with clear counter = 0.
REQ-016 In CLEAR, SHALL write zero to address counter each cycle, increment, and enter READY after address DEPTH-1 (exactly DEPTH cycles of busy=1).
REQ-017 While busy=1, SHALL ignore all a_*/b_* requests: no memory update, no rvalid.
REQ-018 In READY, SHALL treat en=1,we=1 as a write of bytes with be=1 only; be=0 bytes unchanged.
REQ-019 In READY, SHALL treat en=1,we=0 as a read; rvalid pulses and rdata updates at read latency (REQ-030/031).
REQ-020 SHALL hold rdata at its last value when no read completes; write requests produce no rvalid.
REQ-021 Both ports SHALL operate independently and concurrently, any address combination.
REQ-022 Both ports write same address same cycle: port A bytes win where both be set; other bytes taken from whichever port enables them; collision pulses next cycle.
REQ-023 Writes to different addresses, or same address with one read: collision stays 0.
REQ-024 One port reads address X while the other writes X: RDW_MODE=0 returns pre-write word; RDW_MODE=1 returns word with written bytes merged.
REQ-025 Both ports reading the same address SHALL both return identical data.
REQ-026 Addresses SHALL be used modulo DEPTH; no out-of-range condition exists.

Reset
REQ-027 On reset: a_rdata, b_rdata = 0; a_rvalid, b_rvalid, collision = 0; busy = 1 on the cycle after reset is sampled.
REQ-028 Reset asserted mid-CLEAR SHALL restart the sweep from address 0; reset mid-READY SHALL discard in-flight reads (no rvalid).
REQ-029 Memory contents SHALL be all-zero when busy first deasserts.

Configuration
REQ-030 Without DPRAM_OUTREG_EN: read latency 1 (rdata/rvalid on the edge after the request).
REQ-031 With DPRAM_OUTREG_EN defined: an extra output register stage on rdata and rvalid per port; read latency 2; RDW and collision rules unchanged; the extra stage is cleared by reset.

Verification
REQ-032 Reset 1 cycle, release -> busy=1 for 16 cycles, then 0; reads of addresses 0..15 all return 0x0000.
REQ-033 A writes 0xBEEF @3, be=11; next cycle B reads @3 -> b_rdata=0xBEEF, b_rvalid pulse at latency 1 (2 with macro).
REQ-034 @5 = 0x1234; A writes 0xAB00 be=10 -> @5 = 0xAB34.
REQ-035 A writes 0x1111 be=11 and B writes 0x2222 be=11 both @7, same cycle -> @7 = 0x1111, collision pulses once.
REQ-036 @9 = 0x0F0F; A reads @9 while B writes 0xF0F0 @9 -> a_rdata 0x0F0F (RDW_MODE=0), 0xF0F0 (RDW_MODE=1).
REQ-037 Reset asserted at sweep address 8 -> sweep restarts, busy=1 for a further 16 cycles; requests during busy have no effect.
